enigma_rotor_stepper: RTL and testbench

- Upstream stage of the rotor substitution path. Accepts one keyed letter (0-25) at a time.
- On each accepted key, advances the three rotor positions using the Enigma odometer rule, including the middle-rotor double-step.
- Presents the letter plus the post-step positions (r1/r2/r3) to the combinational rotor path through a one-entry valid/ready output register.
- Stepping happens before encryption, as on the real machine.

---
 rtl/enigma_rotor_stepper.sv | 71 +++++++
 tb/tb_enigma_rotor_stepper.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/enigma_rotor_stepper.sv
// enigma_rotor_stepper: Enigma odometer stepping (with double-step) feeding a one-entry valid/ready output register
module enigma_rotor_stepper #(
  parameter int unsigned R1_NOTCH = 16,
  parameter int unsigned R2_NOTCH = 4,
  parameter int unsigned R3_NOTCH = 21,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [5:0]       key_in,
  output logic             key_ready,
  input  logic             load,
  input  logic [5:0]       load_r1,
  input  logic [5:0]       load_r2,
  input  logic [5:0]       load_r3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       data_out,
  output logic [5:0]       r1_pos,
  output logic [5:0]       r2_pos,
  output logic [5:0]       r3_pos,
  output logic             r3_at_notch,
  output logic             err,
  output logic [CNT_W-1:0] char_count
);
  localparam logic [5:0] N1 = 6'(R1_NOTCH);
  localparam logic [5:0] N2 = 6'(R2_NOTCH);
  localparam logic [5:0] N3 = 6'(R3_NOTCH);
  logic load_ok, take, accept, bad_key, step2, step3;
  function automatic logic [5:0] inc(input logic [5:0] x);
    return x == 6'd25 ? 6'd0 : x + 6'd1;
  endfunction
  assign key_ready   = !out_valid || out_ready;
  assign load_ok     = load_r1 <= 6'd25 && load_r2 <= 6'd25 && load_r3 <= 6'd25;
  assign take        = key_valid && key_ready && !load;
  assign accept      = take && key_in <= 6'd25;
  assign bad_key     = take && key_in > 6'd25;
  assign step2       = r1_pos == N1 || r2_pos == N2;
  assign step3       = r2_pos == N2;
  assign r3_at_notch = r3_pos == N3;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r1_pos     <= '0;
      r2_pos     <= '0;
      r3_pos     <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      char_count <= '0;
    end else begin
      err <= (load && !load_ok) || bad_key;
      if (load && load_ok) begin
        r1_pos     <= load_r1;
        r2_pos     <= load_r2;
        r3_pos     <= load_r3;
        out_valid  <= 1'b0;
        char_count <= '0;
      end else if (accept) begin
        r1_pos     <= inc(r1_pos);
        r2_pos     <= step2 ? inc(r2_pos) : r2_pos;
        r3_pos     <= step3 ? inc(r3_pos) : r3_pos;
        data_out   <= key_in;
        out_valid  <= 1'b1;
        char_count <= char_count + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// tb_enigma_rotor_stepper: directed vector table plus randomized run against an arithmetic rotor model
module tb_enigma_rotor_stepper;
  logic clk = 1'b0;
  logic rst, key_valid, load, out_ready;
  logic [5:0] key_in, load_r1, load_r2, load_r3;
  logic key_ready, out_valid, r3_at_notch, err;
  logic [5:0] data_out, r1_pos, r2_pos, r3_pos;
  logic [15:0] char_count;

  always #5 clk = ~clk;

  enigma_rotor_stepper dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .load(load), .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .r1_pos(r1_pos), .r2_pos(r2_pos), .r3_pos(r3_pos), .r3_at_notch(r3_at_notch),
    .err(err), .char_count(char_count)
  );

  typedef struct {
    int rst, ld, l1, l2, l3, kv, key, ordy;
    int v, d, p1, p2, p3, cnt, e, kr;
  } vec_t;

  vec_t tbl[19];
  int tests = 0;
  int fails = 0;

  int m1, m2, m3, md, mc;
  bit mv, me;

  function automatic vec_t mk(int rst_, int ld, int l1, int l2, int l3, int kv, int key, int ordy,
                              int v, int d, int p1, int p2, int p3, int cnt, int e, int kr);
    vec_t r;
    r.rst = rst_; r.ld = ld; r.l1 = l1; r.l2 = l2; r.l3 = l3; r.kv = kv; r.key = key; r.ordy = ordy;
    r.v = v; r.d = d; r.p1 = p1; r.p2 = p2; r.p3 = p3; r.cnt = cnt; r.e = e; r.kr = kr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int r, input int ld, input int l1, input int l2, input int l3,
                       input int kv, input int k, input int ordy);
    rst = r[0]; load = ld[0]; load_r1 = 6'(l1); load_r2 = 6'(l2); load_r3 = 6'(l3);
    key_valid = kv[0]; key_in = 6'(k); out_ready = ordy[0];
  endtask

  task automatic model(input int r, input int ld, input int l1, input int l2, input int l3,
                       input int kv, input int k, input int ordy);
    bit ready, s2, s3;
    ready = !mv || ordy != 0;
    if (r == 0) begin
      m1 = 0; m2 = 0; m3 = 0; md = 0; mc = 0; mv = 0; me = 0;
      return;
    end
    me = 0;
    if (ld != 0) begin
      if (l1 < 26 && l2 < 26 && l3 < 26) begin
        m1 = l1; m2 = l2; m3 = l3; mv = 0; mc = 0;
      end else begin
        me = 1;
        if (mv && ordy != 0) mv = 0;
      end
      return;
    end
    if (kv != 0 && ready && k < 26) begin
      s2 = (m1 == 16) || (m2 == 4);
      s3 = (m2 == 4);
      m1 = (m1 + 1) % 26;
      if (s2) m2 = (m2 + 1) % 26;
      if (s3) m3 = (m3 + 1) % 26;
      md = k; mv = 1; mc = (mc + 1) % 65536;
    end else begin
      if (kv != 0 && ready) me = 1;
      if (mv && ordy != 0) mv = 0;
    end
  endtask

  initial begin
    //          rst ld l1 l2 l3 kv key ordy |  v  d  p1 p2 p3 cnt e kr
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 7, 1,   1, 7, 1, 0, 0, 1, 0, 1);
    tbl[3]  = mk(1, 1, 16, 3, 0, 0, 0, 1,  0, 7, 16, 3, 0, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 0, 0, 1, 0, 1,   1, 0, 17, 4, 0, 1, 0, 1);
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 0, 1,   1, 0, 18, 5, 1, 2, 0, 1);
    tbl[6]  = mk(1, 1, 16, 4, 25, 0, 0, 1, 0, 0, 16, 4, 25, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 3, 1,   1, 3, 17, 5, 0, 1, 0, 1);
    tbl[8]  = mk(1, 1, 25, 0, 0, 0, 0, 1,  0, 3, 25, 0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 3, 1,   1, 3, 0, 0, 0, 1, 0, 1);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 26, 1,  0, 3, 0, 0, 0, 1, 1, 1);
    tbl[11] = mk(1, 1, 5, 30, 5, 0, 0, 1,  0, 3, 0, 0, 0, 1, 1, 1);
    tbl[12] = mk(1, 1, 1, 2, 3, 1, 9, 1,   0, 3, 1, 2, 3, 0, 0, 1);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 5, 1,   1, 5, 2, 2, 3, 1, 0, 1);
    tbl[14] = mk(1, 0, 0, 0, 0, 1, 4, 0,   1, 5, 2, 2, 3, 1, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 1, 4, 0,   1, 5, 2, 2, 3, 1, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 4, 0,   1, 5, 2, 2, 3, 1, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 1, 9, 1,   1, 9, 3, 2, 3, 2, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 1, 2, 1,   0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].ld, tbl[i].l1, tbl[i].l2, tbl[i].l3, tbl[i].kv, tbl[i].key, tbl[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].v));
      chk($sformatf("row%0d.data_out", i), 64'(data_out), 64'(tbl[i].d));
      chk($sformatf("row%0d.r1_pos", i), 64'(r1_pos), 64'(tbl[i].p1));
      chk($sformatf("row%0d.r2_pos", i), 64'(r2_pos), 64'(tbl[i].p2));
      chk($sformatf("row%0d.r3_pos", i), 64'(r3_pos), 64'(tbl[i].p3));
      chk($sformatf("row%0d.char_count", i), 64'(char_count), 64'(tbl[i].cnt));
      chk($sformatf("row%0d.err", i), 64'(err), 64'(tbl[i].e));
      chk($sformatf("row%0d.key_ready", i), 64'(key_ready), 64'(tbl[i].kr));
    end
    for (int c = 0; c < 3000; c++) begin
      int r, ld, l1, l2, l3, kv, k, ordy;
      r    = (c == 0 || $urandom_range(0, 199) == 0) ? 0 : 1;
      ld   = ($urandom_range(0, 15) == 0) ? 1 : 0;
      l1   = ($urandom_range(0, 9) == 0) ? $urandom_range(26, 63) : $urandom_range(0, 25);
      l2   = ($urandom_range(0, 1) == 0) ? $urandom_range(2, 5) : $urandom_range(0, 27);
      l3   = $urandom_range(0, 26);
      kv   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      k    = ($urandom_range(0, 11) == 0) ? $urandom_range(26, 63) : $urandom_range(0, 25);
      ordy = ($urandom_range(0, 2) != 0) ? 1 : 0;
      drive(r, ld, l1, l2, l3, kv, k, ordy);
      model(r, ld, l1, l2, l3, kv, k, ordy);
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d {v,d,r1,r2,r3,cnt,err,notch,kr}", c),
          {20'd0, out_valid, data_out, r1_pos, r2_pos, r3_pos, char_count, err, r3_at_notch, key_ready},
          {20'd0, mv, 6'(md), 6'(m1), 6'(m2), 6'(m3), 16'(mc), me, m3 == 21, !mv || ordy != 0});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
